// File: rtl/mux24.sv
// Transmit side of the 24-slot operator/channel TDM bus: stores one value per slot and
// serialises them in bus order. Define MUX24_DBLBUF_EN for frame-coherent double buffering.
module mux24 #(
  parameter int         width = 10,
  parameter logic [4:0] pos0  = 5'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             wr_en,
  input  logic [2:0]       wr_ch,
  input  logic [1:0]       wr_op,
  input  logic [width-1:0] wr_data,
  output logic [width-1:0] mixed,
  output logic [4:0]       cnt,
  output logic             zero,
  output logic             pending
);

  logic [4:0]       next_cnt;
  logic [5:0]       rd_sum;
  logic [4:0]       rd_idx;
  logic [4:0]       wr_idx;
  logic             wr_ok;
  logic [width-1:0] rd_val;
  logic [width-1:0] active [24];

  always_comb begin
    next_cnt = (cnt == 5'd23) ? 5'd0 : cnt + 5'd1;
    rd_sum   = {1'b0, next_cnt} + {1'b0, pos0};
    // pos0 may be up to 31, so the sum can wrap past 24 twice
    if (rd_sum >= 6'd48)      rd_idx = 5'(rd_sum - 6'd48);
    else if (rd_sum >= 6'd24) rd_idx = 5'(rd_sum - 6'd24);
    else                      rd_idx = rd_sum[4:0];
  end

  // Bus order is S1, S3, S2, S4 while wr_op numbers them S1, S2, S3, S4
  always_comb begin
    case (wr_op)
      2'd0:    wr_idx = {2'b00, wr_ch};
      2'd1:    wr_idx = {2'b00, wr_ch} + 5'd12;
      2'd2:    wr_idx = {2'b00, wr_ch} + 5'd6;
      default: wr_idx = {2'b00, wr_ch} + 5'd18;
    endcase
    wr_ok = wr_en && (wr_ch <= 3'd5);
  end

  assign zero = (cnt == 5'd0);

`ifdef MUX24_DBLBUF_EN
  logic             boundary;
  logic [width-1:0] shadow [24];
  logic [width-1:0] staged [24];

  // staged folds this cycle's write into the shadow so a boundary write joins the copy
  always_comb begin
    for (int i = 0; i < 24; i++) staged[i] = shadow[i];
    if (wr_ok) staged[wr_idx] = wr_data;
    boundary = clk_en && (cnt == 5'd23);
    rd_val   = boundary ? staged[rd_idx] : active[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 24; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
      pending <= 1'b0;
    end else begin
      for (int i = 0; i < 24; i++) shadow[i] <= staged[i];
      if (boundary) begin
        for (int i = 0; i < 24; i++) active[i] <= staged[i];
        pending <= 1'b0;
      end else if (wr_ok) begin
        pending <= 1'b1;
      end
    end
  end
`else
  assign rd_val  = active[rd_idx];
  assign pending = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 24; i++) active[i] <= '0;
    end else if (wr_ok) begin
      active[wr_idx] <= wr_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 5'd0;
      mixed <= '0;
    end else if (clk_en) begin
      cnt   <= next_cnt;
      mixed <= rd_val;
    end
  end

endmodule
